// File: rtl/cps_pkg.sv
// Shared constants for the car-parking input front-end and the parking FSM.
// Password reference digits live here so the FSM and its bench agree on one definition.
package cps_pkg;

    localparam int CPS_DEBOUNCE_DEFAULT = 4;
    localparam int CPS_PW_WIDTH         = 2;
    localparam int CPS_ATTEMPT_MAX      = 7;
    localparam int CPS_ATTEMPT_W        = 3;

    localparam logic [CPS_PW_WIDTH-1:0] CPS_PW1_OK = 2'b01;
    localparam logic [CPS_PW_WIDTH-1:0] CPS_PW2_OK = 2'b10;

    typedef logic [CPS_ATTEMPT_W-1:0] cps_attempt_t;

    // Saturating increment used by the attempt counter.
    function automatic cps_attempt_t cps_sat_inc(input cps_attempt_t v, input cps_attempt_t max_v);
        return (v >= max_v) ? max_v : v + cps_attempt_t'(1);
    endfunction

endpackage

// File: rtl/cps_debounce.sv
// One debounced channel: two-flop synchroniser, run-length counter, stable level
// and a registered one-cycle pulse on each debounced 0->1 transition.
module cps_debounce
    import cps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CPS_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic level,
    output logic rise
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_dly_q;
    logic             rise_q, rise_d;

    // The counter only advances while the synced level disagrees with the stable one,
    // and is reset on a flip, so it can never exceed CNT_LAST.
    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = stable_q & ~stable_dly_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            rise_q       <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            rise_q       <= rise_d;
        end
    end

    assign level = stable_q;
    assign rise  = rise_q;

endmodule

// File: rtl/cps_input_conditioner.sv
// Front-end for the parking FSM: debounced sensors, password capture on a debounced
// load press, and a saturating count of entry attempts since the last vehicle arrival.
module cps_input_conditioner
    import cps_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = CPS_DEBOUNCE_DEFAULT,
    parameter int PW_WIDTH        = CPS_PW_WIDTH,
    parameter int ATTEMPT_MAX     = CPS_ATTEMPT_MAX
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sensor_entrance_raw,
    input  logic                sensor_exit_raw,
    input  logic                pw_load_raw,
    input  logic [PW_WIDTH-1:0] password_1_raw,
    input  logic [PW_WIDTH-1:0] password_2_raw,
    output logic                sensor_entrance,
    output logic                sensor_exit,
    output logic                entrance_rise,
    output logic                exit_rise,
    output logic [PW_WIDTH-1:0] password_1,
    output logic [PW_WIDTH-1:0] password_2,
    output logic                pw_valid,
    output logic [2:0]          attempt_cnt
);

    localparam cps_attempt_t ATT_MAX = cps_attempt_t'(ATTEMPT_MAX);

    logic load_level;
    logic load_rise;

    logic [PW_WIDTH-1:0] pw1_s1_q, pw1_s2_q;
    logic [PW_WIDTH-1:0] pw2_s1_q, pw2_s2_q;
    logic [PW_WIDTH-1:0] pw1_q, pw1_d;
    logic [PW_WIDTH-1:0] pw2_q, pw2_d;
    logic                pw_valid_q;
    cps_attempt_t        attempt_q, attempt_d;

    cps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_entrance (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sensor_entrance_raw),
        .level   (sensor_entrance),
        .rise    (entrance_rise)
    );

    cps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_exit (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sensor_exit_raw),
        .level   (sensor_exit),
        .rise    (exit_rise)
    );

    cps_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (pw_load_raw),
        .level   (load_level),
        .rise    (load_rise)
    );

    // Password lines are only synchronised: capture happens well after they settle.
    always_comb begin
        pw1_d     = load_rise ? pw1_s2_q : pw1_q;
        pw2_d     = load_rise ? pw2_s2_q : pw2_q;
        attempt_d = entrance_rise ? '0 : attempt_q;
        if (load_rise) begin
            attempt_d = cps_sat_inc(attempt_d, ATT_MAX);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pw1_s1_q   <= '0;
            pw1_s2_q   <= '0;
            pw2_s1_q   <= '0;
            pw2_s2_q   <= '0;
            pw1_q      <= '0;
            pw2_q      <= '0;
            pw_valid_q <= 1'b0;
            attempt_q  <= '0;
        end else begin
            pw1_s1_q   <= password_1_raw;
            pw1_s2_q   <= pw1_s1_q;
            pw2_s1_q   <= password_2_raw;
            pw2_s2_q   <= pw2_s1_q;
            pw1_q      <= pw1_d;
            pw2_q      <= pw2_d;
            pw_valid_q <= load_rise;
            attempt_q  <= attempt_d;
        end
    end

    // The debounced load level itself is not needed downstream; only its rise captures.
    logic load_level_unused;
    assign load_level_unused = load_level;

    assign password_1  = pw1_q;
    assign password_2  = pw2_q;
    assign pw_valid    = pw_valid_q;
    assign attempt_cnt = attempt_q;

endmodule

// File: tb/tb_cps_input_conditioner.sv
// Bench for cps_input_conditioner: directed scenarios plus random traffic, every cycle
// compared against a window-based reference model of the debounce/capture rules.
module tb_cps_input_conditioner;
    import cps_pkg::*;

    localparam int D = CPS_DEBOUNCE_DEFAULT;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ent_raw, ext_raw, load_raw;
    logic [1:0] pw1_raw, pw2_raw;
    logic       sensor_entrance, sensor_exit, entrance_rise, exit_rise, pw_valid;
    logic [1:0] password_1, password_2;
    logic [2:0] attempt_cnt;

    int checks = 0;
    int errors = 0;
    int ent_p, ext_p, both_p, val_p, ent_lvl;

    // Reference model state
    bit       hist [3][H];
    bit [1:0] hpw1 [H];
    bit [1:0] hpw2 [H];
    bit       m_stab [3];
    bit       m_prev [3];
    bit       m_rise [3];
    bit [1:0] m_pw1, m_pw2;
    bit       m_valid;
    int       m_att;

    always #5 clk = ~clk;

    cps_input_conditioner dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .sensor_entrance_raw (ent_raw),
        .sensor_exit_raw     (ext_raw),
        .pw_load_raw         (load_raw),
        .password_1_raw      (pw1_raw),
        .password_2_raw      (pw2_raw),
        .sensor_entrance     (sensor_entrance),
        .sensor_exit         (sensor_exit),
        .entrance_rise       (entrance_rise),
        .exit_rise           (exit_rise),
        .password_1          (password_1),
        .password_2          (password_2),
        .pw_valid            (pw_valid),
        .attempt_cnt         (attempt_cnt)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 3; c++) begin
            for (int j = 0; j < H; j++) hist[c][j] = 1'b0;
            m_stab[c] = 1'b0;
            m_prev[c] = 1'b0;
            m_rise[c] = 1'b0;
        end
        for (int j = 0; j < H; j++) begin
            hpw1[j] = '0;
            hpw2[j] = '0;
        end
        m_pw1 = '0; m_pw2 = '0; m_valid = 1'b0; m_att = 0;
    endtask

    // One clock edge of the spec rules: a level flips once the last D synced samples
    // (raw delayed two edges) all disagree with it.
    task automatic model_edge();
        bit cap, all_diff;
        bit nr [3];
        bit rawv [3];
        rawv[0] = ent_raw; rawv[1] = ext_raw; rawv[2] = load_raw;
        for (int c = 0; c < 3; c++) begin
            for (int j = H - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
            hist[c][0] = rawv[c];
        end
        for (int j = H - 1; j > 0; j--) begin
            hpw1[j] = hpw1[j-1];
            hpw2[j] = hpw2[j-1];
        end
        hpw1[0] = pw1_raw; hpw2[0] = pw2_raw;
        cap = m_rise[2];
        if (cap) begin
            m_pw1 = hpw1[2];
            m_pw2 = hpw2[2];
        end
        m_valid = cap;
        if (m_rise[0]) m_att = 0;
        if (cap && m_att < CPS_ATTEMPT_MAX) m_att++;
        for (int c = 0; c < 3; c++) begin
            nr[c] = m_stab[c] & ~m_prev[c];
            m_prev[c] = m_stab[c];
            all_diff = 1'b1;
            for (int j = 2; j <= D + 1; j++)
                if (hist[c][j] == m_stab[c]) all_diff = 1'b0;
            if (all_diff) m_stab[c] = ~m_stab[c];
            m_rise[c] = nr[c];
        end
    endtask

    task automatic compare_all();
        chk("sensor_entrance", 8'(sensor_entrance), 8'(m_stab[0]));
        chk("sensor_exit",     8'(sensor_exit),     8'(m_stab[1]));
        chk("entrance_rise",   8'(entrance_rise),   8'(m_rise[0]));
        chk("exit_rise",       8'(exit_rise),       8'(m_rise[1]));
        chk("password_1",      8'(password_1),      8'(m_pw1));
        chk("password_2",      8'(password_2),      8'(m_pw2));
        chk("pw_valid",        8'(pw_valid),        8'(m_valid));
        chk("attempt_cnt",     8'(attempt_cnt),     8'(m_att));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset_n) model_clear();
        else          model_edge();
        #1;
        compare_all();
        ent_p   += int'(entrance_rise);
        ext_p   += int'(exit_rise);
        both_p  += int'(entrance_rise && exit_rise);
        val_p   += int'(pw_valid);
        ent_lvl += int'(sensor_entrance);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_counts();
        ent_p = 0; ext_p = 0; both_p = 0; val_p = 0; ent_lvl = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_outs"}, {sensor_entrance, sensor_exit, entrance_rise, exit_rise,
                             pw_valid, attempt_cnt}, 8'h00);
        chk({tag, "_pw"}, {4'h0, password_1, password_2}, 8'h00);
    endtask

    initial begin
        clr_counts();
        model_clear();
        // Reset held with every raw input high
        reset_n = 1'b0;
        ent_raw = 1'b1; ext_raw = 1'b1; load_raw = 1'b1;
        pw1_raw = 2'b11; pw2_raw = 2'b11;
        #1;
        chk_all_zero("reset_hold");
        steps(3);
        chk_all_zero("reset_hold_clk");
        reset_n = 1'b1;
        clr_counts();
        steps(5);
        chk("release_edge5_level", 8'(sensor_entrance), 8'h00);
        step();
        chk("release_edge6_level", 8'(sensor_entrance), 8'h01);
        steps(6);
        chk("release_ent_pulses", 8'(ent_p), 8'h01);

        // Glitches: 3 synced cycles is too short, 4 is just enough
        ent_raw = 1'b0; ext_raw = 1'b0; load_raw = 1'b0;
        pw1_raw = 2'b00; pw2_raw = 2'b00;
        steps(12);
        clr_counts();
        ent_raw = 1'b1; steps(3);
        ent_raw = 1'b0; steps(10);
        chk("glitch3_pulses", 8'(ent_p), 8'h00);
        chk("glitch3_level_cycles", 8'(ent_lvl), 8'h00);
        clr_counts();
        ent_raw = 1'b1; steps(4);
        ent_raw = 1'b0; steps(12);
        chk("pulse4_pulses", 8'(ent_p), 8'h01);

        // Capture, then raw password changes while load is still held
        clr_counts();
        pw1_raw = CPS_PW1_OK; pw2_raw = CPS_PW2_OK;
        load_raw = 1'b1; steps(10);
        pw1_raw = 2'b11; pw2_raw = 2'b00; steps(6);
        chk("capture_pw1", 8'(password_1), 8'(CPS_PW1_OK));
        chk("capture_pw2", 8'(password_2), 8'(CPS_PW2_OK));
        chk("capture_valid_pulses", 8'(val_p), 8'h01);
        chk("capture_attempt", 8'(attempt_cnt), 8'h01);
        load_raw = 1'b0; steps(8);

        // Saturation, clear by entrance, coincident clear+count
        for (int p = 0; p < 9; p++) begin
            load_raw = 1'b1; steps(6);
            load_raw = 1'b0; steps(6);
        end
        steps(4);
        chk("attempt_saturated", 8'(attempt_cnt), 8'h07);
        ent_raw = 1'b1; steps(8);
        chk("attempt_cleared", 8'(attempt_cnt), 8'h00);
        ent_raw = 1'b0; steps(8);
        ent_raw = 1'b1; load_raw = 1'b1; steps(10);
        chk("attempt_clear_then_count", 8'(attempt_cnt), 8'h01);
        ent_raw = 1'b0; load_raw = 1'b0; steps(8);

        // Simultaneous sensors
        clr_counts();
        ent_raw = 1'b1; ext_raw = 1'b1; steps(10);
        chk("simul_both_pulse", 8'(both_p), 8'h01);
        chk("simul_ent_pulses", 8'(ent_p), 8'h01);
        chk("simul_ext_pulses", 8'(ext_p), 8'h01);
        chk("simul_levels", {6'd0, sensor_entrance, sensor_exit}, 8'h03);
        ent_raw = 1'b0; ext_raw = 1'b0; steps(8);

        // Reset in the middle of a rising debounce aborts it
        ent_raw = 1'b1; ext_raw = 1'b1; steps(3);
        reset_n = 1'b0;
        model_clear();
        #1;
        compare_all();
        chk_all_zero("midreset");
        ent_raw = 1'b0; ext_raw = 1'b0;
        steps(2);
        reset_n = 1'b1;
        clr_counts();
        steps(12);
        chk("midreset_ent_pulses", 8'(ent_p), 8'h00);
        chk("midreset_ext_pulses", 8'(ext_p), 8'h00);

        // Random traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(5, 0) == 0) ent_raw  = ~ent_raw;
            if ($urandom_range(5, 0) == 0) ext_raw  = ~ext_raw;
            if ($urandom_range(4, 0) == 0) load_raw = ~load_raw;
            pw1_raw = 2'($urandom);
            pw2_raw = 2'($urandom);
            if ($urandom_range(149, 0) == 0) begin
                reset_n = 1'b0;
                model_clear();
                #1;
                compare_all();
                step();
                reset_n = 1'b1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
